// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multi-cycle CPU control path: opcodes, FSM state
// encodings, ALU function codes, PC source codes and register-destination
// codes, plus small opcode classification helpers.
package multicycle_control_unit_pkg;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   // FSM state encodings
   localparam logic [2:0] S_IF     = 3'b000;
   localparam logic [2:0] S_ID     = 3'b001;
   localparam logic [2:0] S_EXE_LS = 3'b010;
   localparam logic [2:0] S_MEM    = 3'b011;
   localparam logic [2:0] S_WB_L   = 3'b100;
   localparam logic [2:0] S_EXE_BR = 3'b101;
   localparam logic [2:0] S_EXE_AL = 3'b110;
   localparam logic [2:0] S_WB_AL  = 3'b111;

   // ALU function codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // PC source select
   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_RS     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   // Register file write destination
   localparam logic [1:0] RD_RA = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RD = 2'b10;

   // Instructions that go through EXE_AL / WB_AL
   function automatic logic is_alu_op(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
         OP_ORI, OP_SLL, OP_SLT:                 return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_control_decoder.sv
// Purely combinational control decoder: (state, opcode, zero) -> every
// datapath select and enable. Enables here are raw; the top gates them
// with reset.
// Ports: state, opcode, zero in; pc_wre, ir_wre, reg_wre, m_rd, m_wr,
// alu_src_a, alu_src_b, ext_sel, alu_op, reg_dst, wr_reg_d_src,
// db_data_src, pc_src out.
module control_decoder
   import multicycle_control_unit_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 3
) (
   input  logic [STW-1:0] state,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   output logic           pc_wre,
   output logic           ir_wre,
   output logic           reg_wre,
   output logic           m_rd,
   output logic           m_wr,
   output logic           alu_src_a,
   output logic           alu_src_b,
   output logic           ext_sel,
   output logic [2:0]     alu_op,
   output logic [1:0]     reg_dst,
   output logic           wr_reg_d_src,
   output logic           db_data_src,
   output logic [1:0]     pc_src
);

   always_comb begin
      pc_wre       = 1'b0;
      ir_wre       = 1'b0;
      reg_wre      = 1'b0;
      m_rd         = 1'b0;
      m_wr         = 1'b0;
      pc_src       = PC_NEXT;
      alu_op       = ALU_ADD;
      alu_src_a    = (opcode == OP_SLL);
      alu_src_b    = (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                     (opcode == OP_SW)   || (opcode == OP_LW);
      ext_sel      = (opcode != OP_ORI);
      wr_reg_d_src = (opcode != OP_JAL);
      db_data_src  = (opcode == OP_LW);

      case (opcode)
         OP_ADDI, OP_ORI, OP_LW:                         reg_dst = RD_RT;
         OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT:  reg_dst = RD_RD;
         default:                                        reg_dst = RD_RA;
      endcase

      // IF keeps the ALU on add so the reset/fetch view is a clean default
      if (state != S_IF) begin
         case (opcode)
            OP_SUB, OP_BEQ: alu_op = ALU_SUB;
            OP_SLL:         alu_op = ALU_SLL;
            OP_OR, OP_ORI:  alu_op = ALU_OR;
            OP_AND:         alu_op = ALU_AND;
            OP_SLT:         alu_op = ALU_SLT;
            default:        alu_op = ALU_ADD;
         endcase
      end

      case (state)
         S_IF: ir_wre = 1'b1;
         S_ID: begin
            case (opcode)
               OP_J:   begin pc_wre = 1'b1; pc_src = PC_JUMP; end
               OP_JR:  begin pc_wre = 1'b1; pc_src = PC_RS;   end
               OP_JAL: begin pc_wre = 1'b1; pc_src = PC_JUMP; reg_wre = 1'b1; end
               OP_HALT, OP_BEQ, OP_SW, OP_LW: ;
               // undefined opcodes retire here as a nop
               default: pc_wre = !is_alu_op(opcode);
            endcase
         end
         S_EXE_BR: begin
            pc_wre = 1'b1;
            pc_src = zero ? PC_BRANCH : PC_NEXT;
         end
         S_MEM: begin
            m_wr   = (opcode == OP_SW);
            pc_wre = (opcode == OP_SW);
            m_rd   = (opcode == OP_LW);
         end
         S_WB_AL, S_WB_L: begin
            pc_wre  = 1'b1;
            reg_wre = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control FSM sequencing IF/ID/EXE/MEM/WB. Holds the state
// register, next-state logic and the halt flag; output decode lives in
// control_decoder.
// Ports: CLK, RST (async active-low), opcode, zero in; state and all
// datapath selects/enables out, plus halted.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 3
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   output logic [STW-1:0] state,
   output logic           PCWre,
   output logic           IRWre,
   output logic           InsMemRW,
   output logic           ALUSrcA,
   output logic           ALUSrcB,
   output logic           ExtSel,
   output logic [2:0]     ALUOp,
   output logic           RegWre,
   output logic [1:0]     RegDst,
   output logic           WrRegDSrc,
   output logic           DBDataSrc,
   output logic           mRD,
   output logic           mWR,
   output logic [1:0]     PCSrc,
   output logic           halted
);

   logic [STW-1:0] next_state;
   logic           halt_q;
   logic           halt_now;
   logic           pc_wre, ir_wre, reg_wre, m_rd, m_wr;

   assign halt_now = (state == S_ID) && (opcode == OP_HALT);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= S_IF;
         halt_q <= 1'b0;
      end else begin
         state <= next_state;
         if (halt_now) halt_q <= 1'b1;
      end
   end

   always_comb begin
      next_state = S_IF;
      case (state)
         S_IF: next_state = S_ID;
         S_ID: begin
            if (halt_q || opcode == OP_HALT)           next_state = S_ID;
            else if (opcode == OP_BEQ)                 next_state = S_EXE_BR;
            else if (opcode == OP_SW || opcode == OP_LW) next_state = S_EXE_LS;
            else if (is_alu_op(opcode))                next_state = S_EXE_AL;
            else                                       next_state = S_IF;
         end
         S_EXE_LS: next_state = S_MEM;
         S_MEM:    next_state = (opcode == OP_LW) ? S_WB_L : S_IF;
         S_EXE_AL: next_state = S_WB_AL;
         default:  next_state = S_IF;
      endcase
   end

   control_decoder #(.OPW(OPW), .STW(STW)) u_dec (
      .state        (state),
      .opcode       (opcode),
      .zero         (zero),
      .pc_wre       (pc_wre),
      .ir_wre       (ir_wre),
      .reg_wre      (reg_wre),
      .m_rd         (m_rd),
      .m_wr         (m_wr),
      .alu_src_a    (ALUSrcA),
      .alu_src_b    (ALUSrcB),
      .ext_sel      (ExtSel),
      .alu_op       (ALUOp),
      .reg_dst      (RegDst),
      .wr_reg_d_src (WrRegDSrc),
      .db_data_src  (DBDataSrc),
      .pc_src       (PCSrc)
   );

   // Strobes are gated by RST directly so a mid-instruction reset kills
   // them immediately; halt suppresses everything while parked in ID.
   assign PCWre    = RST & pc_wre  & ~halt_q;
   assign IRWre    = RST & ir_wre;
   assign RegWre   = RST & reg_wre & ~halt_q;
   assign mRD      = RST & m_rd;
   assign mWR      = RST & m_wr;
   assign InsMemRW = 1'b1;
   assign halted   = halt_q | halt_now;

endmodule
